// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command decoder: M / R / S / Pddd<CR|LF>.
// Drives measure strobes, run enable and period register for the SR04 controller.
module uart_cmd_decoder #(
  parameter int PERIOD_W       = 10,
  parameter int DEFAULT_PERIOD = 100,
  parameter int MIN_PERIOD     = 60,
  parameter int TIMEOUT_CYC    = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic                cmd_measure,
  output logic                run_en,
  output logic [PERIOD_W-1:0] period_ms,
  output logic                period_upd,
  output logic                cmd_err
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int ACC_W = PERIOD_W + 4;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIGIT,
    TERM
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [1:0]       cnt;
  logic [TMO_W-1:0] tmo;

  logic [7:0]       b;
  logic             is_digit;
  logic             is_eol;
  logic [ACC_W-1:0] acc_next;

  // Case fold: lowercase letters map onto their uppercase codes.
  always_comb begin
    b = rx_data;
    if (rx_data >= 8'h61 && rx_data <= 8'h7A)
      b = rx_data & 8'hDF;
    is_digit = (b >= 8'h30) && (b <= 8'h39);
    is_eol   = (b == 8'h0D) || (b == 8'h0A);
    acc_next = (acc << 3) + (acc << 1) + ACC_W'(b[3:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_measure <= 1'b0;
      run_en      <= 1'b0;
      period_ms   <= PERIOD_W'(DEFAULT_PERIOD);
      period_upd  <= 1'b0;
      cmd_err     <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      tmo         <= '0;
    end else begin
      cmd_measure <= 1'b0;
      period_upd  <= 1'b0;
      cmd_err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_done) begin
            unique case (1'b1)
              (b == 8'h4D): cmd_measure <= 1'b1;
              (b == 8'h52): run_en <= 1'b1;
              (b == 8'h53): run_en <= 1'b0;
              (b == 8'h50): begin
                acc   <= '0;
                cnt   <= '0;
                tmo   <= '0;
                state <= DIGIT;
              end
              (is_eol || b == 8'h20): ;
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        DIGIT: begin
          if (rx_done) begin
            tmo <= '0;
            if (is_digit) begin
              acc <= acc_next;
              cnt <= cnt + 2'd1;
              if (cnt == 2'd2)
                state <= TERM;
            end else begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (tmo == TMO_LAST) begin
            cmd_err <= 1'b1;
            tmo     <= '0;
            state   <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        TERM: begin
          if (rx_done) begin
            tmo   <= '0;
            state <= IDLE;
            if (is_eol && acc >= ACC_W'(MIN_PERIOD)) begin
              period_ms  <= acc[PERIOD_W-1:0];
              period_upd <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (tmo == TMO_LAST) begin
            cmd_err <= 1'b1;
            tmo     <= '0;
            state   <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: command table, directed timeout/reset
// sequences and random byte traffic against a frame-level model.
module tb_uart_cmd_decoder;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       cmd_measure;
  logic       run_en;
  logic [9:0] period_ms;
  logic       period_upd;
  logic       cmd_err;

  uart_cmd_decoder #(
    .PERIOD_W      (10),
    .DEFAULT_PERIOD(100),
    .MIN_PERIOD    (60),
    .TIMEOUT_CYC   (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .cmd_measure(cmd_measure),
    .run_en     (run_en),
    .period_ms  (period_ms),
    .period_upd (period_upd),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: a flag for "inside P frame" plus a digit queue.
  bit m_inp;
  int m_q[$];
  int m_gap;
  bit m_run;
  int m_per;
  bit e_meas, e_upd, e_err;

  int c_meas, c_upd, c_err;

  typedef struct {
    string s;
    bit    run;
    int    per;
    int    nm;
    int    nu;
    int    ne;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic void model_step(input bit done, input logic [7:0] raw);
    int u;
    int v;
    e_meas = 0;
    e_upd  = 0;
    e_err  = 0;
    u = int'(raw);
    if (u >= 97 && u <= 122) u = u - 32;
    if (done) begin
      m_gap = 0;
      if (!m_inp) begin
        if (u == 77) e_meas = 1;
        else if (u == 82) m_run = 1;
        else if (u == 83) m_run = 0;
        else if (u == 80) begin
          m_inp = 1;
          m_q.delete();
        end else if (u == 13 || u == 10 || u == 32) begin
        end else e_err = 1;
      end else if (m_q.size() < 3) begin
        if (u >= 48 && u <= 57) m_q.push_back(u - 48);
        else begin
          e_err = 1;
          m_inp = 0;
        end
      end else begin
        m_inp = 0;
        v = m_q[0] * 100 + m_q[1] * 10 + m_q[2];
        if ((u == 13 || u == 10) && v >= 60) begin
          m_per = v;
          e_upd = 1;
        end else e_err = 1;
      end
    end else if (m_inp) begin
      m_gap++;
      if (m_gap >= T) begin
        e_err = 1;
        m_inp = 0;
      end
    end
  endfunction

  task automatic tick(input bit done, input logic [7:0] b);
    rx_data = b;
    rx_done = done;
    @(posedge clk);
    #1;
    model_step(done, b);
    chk("cycle", int'({cmd_measure, run_en, period_upd, cmd_err, period_ms}),
        int'({e_meas, m_run, e_upd, e_err, 10'(m_per)}));
    c_meas += int'(cmd_measure);
    c_upd  += int'(period_upd);
    c_err  += int'(cmd_err);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rx_done = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_inp = 0;
    m_gap = 0;
    m_run = 0;
    m_per = 100;
    m_q.delete();
    chk("reset", int'({cmd_measure, run_en, period_upd, cmd_err, period_ms}),
        int'({1'b0, 1'b0, 1'b0, 1'b0, 10'd100}));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      tick(1'b1, s[i]);
      tick(1'b0, 8'h00);
    end
    tick(1'b0, 8'h00);
  endtask

  task automatic clr_counts();
    c_meas = 0;
    c_upd  = 0;
    c_err  = 0;
  endtask

  string alpha;
  int    gap;

  initial begin
    tv[0]  = '{"M",                 0, 100, 1, 0, 0};
    tv[1]  = '{"r",                 1, 100, 0, 0, 0};
    tv[2]  = '{"S",                 0, 100, 0, 0, 0};
    tv[3]  = '{"P250\015",          0, 250, 0, 1, 0};
    tv[4]  = '{"p075\012",          0,  75, 0, 1, 0};
    tv[5]  = '{"P059\015",          0,  75, 0, 0, 1};
    tv[6]  = '{"P999\012",          0, 999, 0, 1, 0};
    tv[7]  = '{"P2XM",              0, 999, 1, 0, 1};
    tv[8]  = '{"P1234",             0, 999, 0, 0, 1};
    tv[9]  = '{"Q",                 0, 999, 0, 0, 1};
    tv[10] = '{"RM",                1, 999, 1, 0, 0};
    tv[11] = '{" \015\012",         1, 999, 0, 0, 0};
    tv[12] = '{"Ps",                1, 999, 0, 0, 1};
    tv[13] = '{"P060\015",          1,  60, 0, 1, 0};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      clr_counts();
      send_str(tv[i].s);
      chk($sformatf("v%0d_run", i), int'(run_en), int'(tv[i].run));
      chk($sformatf("v%0d_period", i), int'(period_ms), tv[i].per);
      chk($sformatf("v%0d_n_meas", i), c_meas, tv[i].nm);
      chk($sformatf("v%0d_n_upd", i), c_upd, tv[i].nu);
      chk($sformatf("v%0d_n_err", i), c_err, tv[i].ne);
    end

    // Timeout inside a frame, then the orphan digit is a plain error.
    clr_counts();
    tick(1'b1, "P");
    tick(1'b0, 8'h00);
    tick(1'b1, "1");
    tick(1'b0, 8'h00);
    tick(1'b1, "2");
    for (int i = 0; i < T + 2; i++) tick(1'b0, 8'h00);
    chk("tmo_n_err", c_err, 1);
    clr_counts();
    send_str("3\015");
    chk("tmo_tail_n_err", c_err, 1);
    chk("tmo_tail_n_upd", c_upd, 0);
    chk("tmo_period", int'(period_ms), 60);

    // Reset in the middle of a frame.
    tick(1'b1, "P");
    tick(1'b0, 8'h00);
    tick(1'b1, "3");
    do_reset();
    clr_counts();
    send_str("P100\015");
    chk("rst_n_upd", c_upd, 1);
    chk("rst_n_err", c_err, 0);
    chk("rst_period", int'(period_ms), 100);

    // Random traffic, occasionally idling long enough to time out.
    alpha = "MRSPmrspPP0123456789012345\015\012 XQz";
    for (int i = 0; i < 500; i++) begin
      tick(1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
      gap = ($urandom_range(0, 24) == 0) ? T + 1 : $urandom_range(1, 3);
      for (int j = 0; j < gap; j++) tick(1'b0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
